// File: rtl/prng_pkg.sv
// Shared constants and FSM state type for the 16-bit XNOR LFSR generator and checker.
package prng_pkg;

  // Tap mask for bits 15,14,12,3; the new bit is the XNOR of these taps.
  localparam logic [15:0] LFSR16_TAPS   = 16'hD008;
  localparam logic [15:0] LFSR16_LOCKUP = 16'hFFFF;

  typedef enum logic [1:0] {
    SEED   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } chk_state_e;

  function automatic logic lfsr16_next_bit(input logic [15:0] s);
    return ~(^(s & LFSR16_TAPS));
  endfunction

endpackage

// File: rtl/prng_lfsr16_predict.sv
// Combinational next-bit predictor for the 16-bit XNOR LFSR (shift left, new bit in LSB).
module prng_lfsr16_predict
  import prng_pkg::*;
(
  input  logic [15:0] lfsr_state,
  output logic        pred
);

  always_comb begin
    pred = lfsr16_next_bit(lfsr_state);
  end

endmodule

// File: rtl/prng_stream_checker.sv
// Serial checker that self-seeds from a 16-bit XNOR LFSR stream, verifies, locks and counts errors.
// Optional bit_count output is enabled by defining PRNG_CHK_BITCNT_EN.
module prng_stream_checker
  import prng_pkg::*;
#(
  parameter int unsigned VERIFY_BITS = 16,
  parameter int unsigned WINDOW      = 64,
  parameter int unsigned ERR_THRESH  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        bit_valid,
  input  logic        bit_in,
  input  logic        err_clear,
  output logic        lock,
  output logic        err_pulse,
  output logic [15:0] err_count,
`ifdef PRNG_CHK_BITCNT_EN
  output logic [31:0] bit_count,
`endif
  output logic [1:0]  state_dbg
);

  chk_state_e  state_q, state_d;
  logic [15:0] sr_q, sr_d;
  logic [3:0]  fill_q, fill_d;
  logic [7:0]  ver_q, ver_d;
  logic [15:0] win_cnt_q, win_cnt_d;
  logic [15:0] win_err_q, win_err_d;
  logic        lock_q, lock_d;
  logic        err_pulse_q, err_pulse_d;
  logic [15:0] err_count_q, err_count_d;

  logic        pred;
  logic        mismatch;
  logic        count_err;
  logic [8:0]  ver_next;
  logic [16:0] win_cnt_next;
  logic [16:0] win_err_next;
  logic [15:0] sr_fill;

  prng_lfsr16_predict u_predict (
    .lfsr_state (sr_q),
    .pred       (pred)
  );

  assign mismatch     = bit_valid && (bit_in != pred);
  assign ver_next     = {1'b0, ver_q} + 9'd1;
  assign win_cnt_next = {1'b0, win_cnt_q} + 17'd1;
  assign win_err_next = {1'b0, win_err_q} + {16'd0, mismatch};
  assign sr_fill      = {sr_q[14:0], bit_in};

  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    fill_d      = fill_q;
    ver_d       = ver_q;
    win_cnt_d   = win_cnt_q;
    win_err_d   = win_err_q;
    lock_d      = lock_q;
    err_pulse_d = 1'b0;
    count_err   = 1'b0;

    case (state_q)
      SEED: begin
        if (bit_valid) begin
          sr_d = sr_fill;
          if (fill_q == 4'd15) begin
            fill_d = 4'd0;
            if (sr_fill != LFSR16_LOCKUP) begin
              state_d = VERIFY;
              ver_d   = 8'd0;
            end
          end else begin
            fill_d = fill_q + 4'd1;
          end
        end
      end

      VERIFY: begin
        if (bit_valid) begin
          sr_d = sr_fill;
          if (mismatch) begin
            err_pulse_d = 1'b1;
            state_d     = SEED;
            fill_d      = 4'd0;
          end else if (ver_next == 9'(VERIFY_BITS)) begin
            state_d   = LOCKED;
            lock_d    = 1'b1;
            ver_d     = 8'd0;
            win_cnt_d = 16'd0;
            win_err_d = 16'd0;
          end else begin
            ver_d = ver_next[7:0];
          end
        end
      end

      LOCKED: begin
        if (bit_valid) begin
          // Flywheel: the register follows its own prediction, so one bad bit costs one error.
          sr_d = {sr_q[14:0], pred};
          if (mismatch) begin
            err_pulse_d = 1'b1;
            count_err   = 1'b1;
          end
          if (win_err_next >= 17'(ERR_THRESH)) begin
            state_d   = SEED;
            lock_d    = 1'b0;
            fill_d    = 4'd0;
            win_cnt_d = 16'd0;
            win_err_d = 16'd0;
          end else if (win_cnt_next == 17'(WINDOW)) begin
            win_cnt_d = 16'd0;
            win_err_d = 16'd0;
          end else begin
            win_cnt_d = win_cnt_next[15:0];
            win_err_d = win_err_next[15:0];
          end
        end
      end

      default: begin
        state_d = SEED;
        fill_d  = 4'd0;
        lock_d  = 1'b0;
      end
    endcase

    err_count_d = err_clear ? 16'd0 : err_count_q;
    if (count_err && (err_count_d != 16'hFFFF)) begin
      err_count_d = err_count_d + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= SEED;
      sr_q        <= 16'd0;
      fill_q      <= 4'd0;
      ver_q       <= 8'd0;
      win_cnt_q   <= 16'd0;
      win_err_q   <= 16'd0;
      lock_q      <= 1'b0;
      err_pulse_q <= 1'b0;
      err_count_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      fill_q      <= fill_d;
      ver_q       <= ver_d;
      win_cnt_q   <= win_cnt_d;
      win_err_q   <= win_err_d;
      lock_q      <= lock_d;
      err_pulse_q <= err_pulse_d;
      err_count_q <= err_count_d;
    end
  end

`ifdef PRNG_CHK_BITCNT_EN
  logic [31:0] bit_count_q, bit_count_d;

  always_comb begin
    bit_count_d = err_clear ? 32'd0 : bit_count_q;
    if ((state_q == LOCKED) && bit_valid && (bit_count_d != 32'hFFFF_FFFF)) begin
      bit_count_d = bit_count_d + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bit_count_q <= 32'd0;
    end else begin
      bit_count_q <= bit_count_d;
    end
  end

  assign bit_count = bit_count_q;
`endif

  assign lock      = lock_q;
  assign err_pulse = err_pulse_q;
  assign err_count = err_count_q;
  assign state_dbg = state_q;

endmodule
